ws2812b_rx: RTL and testbench

- Single-wire WS2812B stream decoder: the receive end of the LED chain protocol.
- Samples a GPIO line driven by our WS2812B transmitter, or a captured chain output, at 50 MHz.
- Decodes NRZ pulse-width bits into 24-bit GRB pixels, counts pixels per frame and flags timing violations.
- Used for loopback self-test of the LED controller on the remote lab boards and as a capture front-end for the web viewer.

---
 rtl/ws2812b_rx.sv | 170 +++++++++++++++++
 tb/tb_ws2812b_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: recovers 24-bit GRB pixels from NRZ pulse widths,
// counts pixels per frame and flags glitches, stuck-high lines, torn pixels and overflow.
module ws2812b_rx #(
  parameter int NLEDS       = 64,
  parameter int TBIT_THRESH = 27,
  parameter int TGLITCH     = 6,
  parameter int THIGH_MAX   = 60,
  parameter int TRESET      = 2500
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        GPIO,
  output logic        pix_valid,
  output logic [23:0] pix_grb,
  output logic [5:0]  pix_idx,
  output logic        frame_done,
  output logic [6:0]  frame_len,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

  localparam logic [11:0] TRESET_M1 = 12'(TRESET - 1);
  localparam logic [11:0] THIGH_M1  = 12'(THIGH_MAX - 1);
  localparam logic [11:0] TGLITCH_C = 12'(TGLITCH);
  localparam logic [11:0] TBIT_C    = 12'(TBIT_THRESH);
  localparam logic [6:0]  NLEDS_C   = 7'(NLEDS);

  state_t state, state_next;

  logic        sync_ff, din_s, din_d, rise, fall;
  logic [11:0] low_cnt, high_cnt;
  logic [4:0]  bit_cnt;
  logic [6:0]  pix_cnt;
  logic [22:0] shreg;
  logic        ovf_seen;

  logic sync_lock, gap, too_long, hi_fall, glitch, bit_ok, bit_val;
  logic word_done, pix_emit, ovf_hit, gap_err, gap_done;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // din_d is the line level the FSM works on; rise/fall are registered so they line up with it.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      sync_ff <= 1'b0;
      din_s   <= 1'b0;
      din_d   <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync_ff <= GPIO;
      din_s   <= sync_ff;
      din_d   <= din_s;
      rise    <= din_s & ~din_d;
      fall    <= ~din_s & din_d;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) state <= SYNC;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    if (sync_lock) state_next = LOW;
      LOW:     if (rise) state_next = HIGH;
      HIGH: begin
        if (too_long || glitch) state_next = SYNC;
        else if (fall)          state_next = LOW;
      end
      default: state_next = SYNC;
    endcase
  end

  always_comb begin
    sync_lock = 1'b0;
    gap       = 1'b0;
    too_long  = 1'b0;
    hi_fall   = 1'b0;
    case (state)
      SYNC:    sync_lock = !din_d && (low_cnt == TRESET_M1);
      LOW:     gap       = !rise && (low_cnt == TRESET_M1);
      HIGH: begin
        too_long = !fall && (high_cnt == THIGH_M1);
        hi_fall  = fall;
      end
      default: ;
    endcase
    glitch    = hi_fall && (high_cnt < TGLITCH_C);
    bit_ok    = hi_fall && !glitch;
    bit_val   = (high_cnt >= TBIT_C);
    word_done = bit_ok && (bit_cnt == 5'd23);
    pix_emit  = word_done && (pix_cnt < NLEDS_C);
    ovf_hit   = word_done && (pix_cnt == NLEDS_C) && !ovf_seen;
    gap_err   = gap && (bit_cnt != 5'd0);
    gap_done  = gap && (pix_cnt != 7'd0);
  end

  // In SYNC low_cnt measures the quiet time needed before we trust the bit boundaries.
  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      low_cnt  <= '0;
      high_cnt <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      shreg    <= '0;
      ovf_seen <= 1'b0;
    end else begin
      case (state)
        SYNC: low_cnt <= din_d ? 12'd0 : sat_inc(low_cnt);
        LOW: begin
          if (rise) begin
            high_cnt <= 12'd1;
            low_cnt  <= 12'd0;
          end else begin
            low_cnt <= sat_inc(low_cnt);
          end
        end
        HIGH: begin
          if (fall) low_cnt  <= glitch ? 12'd0 : 12'd1;
          else      high_cnt <= sat_inc(high_cnt);
        end
        default: ;
      endcase
      if (bit_ok) begin
        shreg   <= {shreg[21:0], bit_val};
        bit_cnt <= word_done ? 5'd0 : bit_cnt + 5'd1;
      end
      if (pix_emit) pix_cnt  <= pix_cnt + 7'd1;
      if (ovf_hit)  ovf_seen <= 1'b1;
      if (sync_lock || gap) begin
        bit_cnt  <= '0;
        pix_cnt  <= '0;
        ovf_seen <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      pix_valid  <= 1'b0;
      pix_grb    <= '0;
      pix_idx    <= '0;
      frame_done <= 1'b0;
      frame_len  <= '0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      pix_valid  <= pix_emit;
      frame_done <= gap_done;
      err        <= glitch || too_long || gap_err || ovf_hit;
      if (pix_emit) begin
        pix_grb <= {shreg, bit_val};
        pix_idx <= pix_cnt[5:0];
      end
      if (gap_done) frame_len <= pix_cnt;
      if (glitch)        err_code <= 2'd0;
      else if (too_long) err_code <= 2'd1;
      else if (gap_err)  err_code <= 2'd2;
      else if (ovf_hit)  err_code <= 2'd3;
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Drives randomized and directed pulse trains into ws2812b_rx and compares the strobes
// against a pulse-level reference model of the protocol.
module tb_ws2812b_rx;
  localparam int NLEDS       = 64;
  localparam int TBIT_THRESH = 27;
  localparam int TGLITCH     = 6;
  localparam int THIGH_MAX   = 60;
  localparam int TRESET      = 2500;
  localparam int GAP         = 2600;
  localparam int EV_PIX      = 0;
  localparam int EV_DONE     = 1;
  localparam int EV_ERR      = 2;

  typedef struct {
    int kind;
    int val;
    int idx;
    int cyc;
  } ev_t;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        GPIO     = 1'b0;
  logic        pix_valid;
  logic [23:0] pix_grb;
  logic [5:0]  pix_idx;
  logic        frame_done;
  logic [6:0]  frame_len;
  logic        err;
  logic [1:0]  err_code;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  bit          m_synced;
  int          m_low_run, m_low_acc, m_bits, m_pix;
  bit          m_ovf;
  logic [23:0] m_word;

  ws2812b_rx dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .GPIO      (GPIO),
    .pix_valid (pix_valid),
    .pix_grb   (pix_grb),
    .pix_idx   (pix_idx),
    .frame_done(frame_done),
    .frame_len (frame_len),
    .err       (err),
    .err_code  (err_code)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_exp(input int kind, input int val, input int idx, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.idx = idx; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_obs(input int kind, input int val, input int idx, input int c);
    ev_t e;
    e.kind = kind; e.val = val; e.idx = idx; e.cyc = c;
    obs_q.push_back(e);
  endtask

  task automatic model_reset();
    m_synced  = 1'b0;
    m_low_run = 0;
    m_low_acc = 0;
    m_bits    = 0;
    m_pix     = 0;
    m_ovf     = 1'b0;
    m_word    = '0;
  endtask

  // Protocol rules applied to whole pulses: a high of n cycles starting at cycle 'start'.
  task automatic model_seg(input logic lvl, input int n, input int start);
    if (!lvl) begin
      if (!m_synced) begin
        m_low_run += n;
        if (m_low_run >= TRESET) begin
          m_synced = 1'b1; m_bits = 0; m_pix = 0; m_ovf = 1'b0; m_low_acc = TRESET;
        end
      end else begin
        if (m_low_acc < TRESET && m_low_acc + n >= TRESET) begin
          if (m_bits != 0) push_exp(EV_ERR, 2, 0, -1);
          if (m_pix != 0)  push_exp(EV_DONE, m_pix, 0, -1);
          m_bits = 0; m_pix = 0; m_ovf = 1'b0;
        end
        m_low_acc = (m_low_acc + n > TRESET) ? TRESET : m_low_acc + n;
      end
    end else if (!m_synced) begin
      m_low_run = 0;
    end else if (n >= THIGH_MAX) begin
      push_exp(EV_ERR, 1, 0, -1);
      m_synced = 1'b0; m_low_run = 0;
    end else if (n < TGLITCH) begin
      push_exp(EV_ERR, 0, 0, -1);
      m_synced = 1'b0; m_low_run = 0;
    end else begin
      m_word    = {m_word[22:0], (n >= TBIT_THRESH) ? 1'b1 : 1'b0};
      m_bits    = m_bits + 1;
      m_low_acc = 0;
      if (m_bits == 24) begin
        m_bits = 0;
        if (m_pix < NLEDS) begin
          push_exp(EV_PIX, int'(m_word), m_pix, start + n + 4);
          m_pix = m_pix + 1;
        end else if (!m_ovf) begin
          push_exp(EV_ERR, 3, 0, -1);
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic lvl, input int n);
    GPIO = lvl;
    model_seg(lvl, n, cyc);
    repeat (n) begin
      @(posedge CLOCK_50);
      #1;
    end
  endtask

  // mode 0: 19/41 and 36/31 timing; mode 1: shortest legal bits; mode 2: random incl. threshold edges
  task automatic send_bit(input logic b, input int mode);
    int h, l, sel;
    case (mode)
      0: begin h = b ? 36 : 19; l = b ? 31 : 41; end
      1: begin h = b ? TBIT_THRESH : TGLITCH; l = 1; end
      default: begin
        sel = int'($urandom_range(0, 2));
        if (b) h = (sel == 0) ? TBIT_THRESH : (sel == 1) ? THIGH_MAX - 1 : int'($urandom_range(28, 58));
        else   h = (sel == 0) ? TGLITCH : (sel == 1) ? TBIT_THRESH - 1 : int'($urandom_range(7, 25));
        l = int'($urandom_range(1, 12));
      end
    endcase
    applyStimulus(1'b1, h);
    applyStimulus(1'b0, l);
  endtask

  task automatic send_pixel(input logic [23:0] w, input int mode);
    for (int i = 23; i >= 0; i--) send_bit(w[i], mode);
  endtask

  task automatic send_bits(input int n, input int mode);
    for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), mode);
  endtask

  task automatic apply_reset(input string tag, input int cycles);
    RESET_N = 1'b0;
    repeat (cycles) begin
      @(posedge CLOCK_50);
      #1;
    end
    checkOutput(tag, 64'({pix_valid, pix_grb, pix_idx, frame_done, frame_len, err, err_code}), 64'd0);
    RESET_N = 1'b1;
    model_reset();
  endtask

  always @(negedge CLOCK_50) begin
    if (RESET_N === 1'b1) begin
      if (err === 1'b1)        push_obs(EV_ERR, int'(err_code), 0, -1);
      if (frame_done === 1'b1) push_obs(EV_DONE, int'(frame_len), 0, -1);
      if (pix_valid === 1'b1)  push_obs(EV_PIX, int'(pix_grb), int'(pix_idx), cyc);
    end
  end

  initial begin
    int n;
    model_reset();
    GPIO = 1'b0;
    #1;
    apply_reset("reset_state", 3);
    applyStimulus(1'b0, GAP);

    send_pixel(24'h00FF00, 0);
    applyStimulus(1'b0, 3000);

    for (int p = 0; p < NLEDS + 1; p++) send_pixel(24'($urandom), 1);
    applyStimulus(1'b0, GAP);

    send_bits(12, 2);
    applyStimulus(1'b0, 3000);

    send_pixel(24'($urandom), 2);
    send_bits(12, 2);
    applyStimulus(1'b0, GAP);

    for (int p = 0; p < 3; p++) send_pixel(24'($urandom), 2);
    applyStimulus(1'b0, GAP);

    send_bits(5, 2);
    applyStimulus(1'b1, 3);
    applyStimulus(1'b0, 10);
    send_bits(6, 2);
    applyStimulus(1'b0, GAP);
    send_pixel(24'($urandom), 2);
    applyStimulus(1'b0, GAP);

    send_bits(3, 2);
    applyStimulus(1'b1, 80);
    applyStimulus(1'b0, GAP);

    send_bits(2, 2);
    applyStimulus(1'b1, THIGH_MAX);
    applyStimulus(1'b0, GAP);

    send_pixel(24'hA5C33C, 2);
    send_bits(10, 2);
    apply_reset("reset_mid_frame", 1);
    send_bits(14, 2);
    send_pixel(24'($urandom), 2);
    applyStimulus(1'b0, GAP);
    send_pixel(24'($urandom), 2);
    send_pixel(24'($urandom), 2);
    applyStimulus(1'b0, GAP);

    checkOutput("event_count", 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("ev%0d_kind_val_idx", i),
                  64'({8'(obs_q[i].kind), 32'(obs_q[i].val), 8'(obs_q[i].idx)}),
                  64'({8'(exp_q[i].kind), 32'(exp_q[i].val), 8'(exp_q[i].idx)}));
      if (exp_q[i].kind == EV_PIX)
        checkOutput($sformatf("ev%0d_pix_cycle", i), 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
